mem_wb_buffer: RTL and testbench

//  MEM/WB pipeline register. Sits between the mem stage and writeback.

---
 rtl/rv32i_types.sv | 36 +++
 rtl/mem_wb_buffer.sv | 132 +++++++++++++
 tb/tb_mem_wb_buffer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I pipeline types.
//   rvfi_t          - RVFI trace fields carried alongside each instruction
//   MEM_WB_stage_t  - payload handed from the mem stage to writeback
//   mem_wb_state_t  - MEM/WB buffer access FSM (IDLE / WAIT)
package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] rvfi_insn;
    logic [XLEN-1:0] rvfi_pc_rdata;
    logic [XLEN-1:0] rvfi_pc_wdata;
    logic [XLEN-1:0] rvfi_mem_addr;
    logic [3:0]      rvfi_mem_rmask;
    logic [3:0]      rvfi_mem_wmask;
    logic [XLEN-1:0] rvfi_mem_rdata;
    logic [XLEN-1:0] rvfi_mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mdr;
    logic [4:0]      rd_addr;
    logic            regf_we;
    logic [2:0]      wb_sel;
    rvfi_t           rvfi_d;
  } MEM_WB_stage_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_wb_state_t;

endpackage

// File: rtl/mem_wb_buffer.sv
// mem_wb_buffer: MEM/WB pipeline register.
//   Holds the MEM-stage instruction until its dmem access completes, stalling
//   the front of the pipe meanwhile, then hands it to writeback with load data
//   merged in and an RVFI retire order tag.
// Ports:
//   clk, rst       clock / async active-low reset
//   mem_out        stage payload from mem (combinational)
//   mem_valid      mem_out is a real instruction
//   dmem_read/write mem stage issues a load / store
//   dmem_resp      outstanding access completes this cycle
//   dmem_rdata     load data, valid with dmem_resp
//   wb_in          registered payload to writeback
//   wb_valid       wb_in retires this cycle
//   mem_stall      freeze IF..EX/MEM (combinational)
//   rvfi_order     order tag of wb_in
//   timeout_err    sticky: an access waited more than TIMEOUT cycles
module mem_wb_buffer
  import rv32i_types::*;
#(
  parameter int unsigned ORDER_W = 64,
  parameter int unsigned TIMEOUT = 0,   // 0 disables the timeout check
  parameter int unsigned TO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  MEM_WB_stage_t      mem_out,
  input  logic               mem_valid,
  input  logic               dmem_read,
  input  logic               dmem_write,
  input  logic               dmem_resp,
  input  logic [31:0]        dmem_rdata,
  output MEM_WB_stage_t      wb_in,
  output logic               wb_valid,
  output logic               mem_stall,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic               timeout_err
);

  localparam logic [TO_W-1:0] TIMEOUT_CNT = TO_W'(TIMEOUT);

  mem_wb_state_t      state_q;
  logic [TO_W-1:0]    wait_cnt;
  logic [ORDER_W-1:0] order_cnt;
  logic               acc;
  logic               rd_acc;
  logic               capture;

  // read+write together is illegal upstream; it still counts as one access
  assign acc    = mem_valid & (dmem_read | dmem_write);
  assign rd_acc = mem_valid & dmem_read;

  // In WAIT the held instruction retires on its response. In IDLE a
  // non-memory instruction retires at once, a memory one only on a
  // zero-wait response; a response with no access is a stale one and ignored.
  assign capture = (state_q == WAIT) ? dmem_resp
                                     : (mem_valid & (~acc | dmem_resp));

  // Stall drops in the response cycle so the pipe advances on the same edge
  // the instruction is captured.
  always_comb begin
    mem_stall = rst & acc & ~dmem_resp;
  end

  // access FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (acc && !dmem_resp) state_q <= WAIT;
        WAIT: if (dmem_resp)         state_q <= IDLE;
        default:                     state_q <= IDLE;
      endcase
    end
  end

  // wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: wait_cnt <= (acc && !dmem_resp) ? TO_W'(1) : '0;
        WAIT: begin
          if (dmem_resp) begin
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + TO_W'(1);
            // flag only; the access keeps waiting for its response
            if (TIMEOUT != 0 && wait_cnt == TIMEOUT_CNT) timeout_err <= 1'b1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

  // payload register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_in      <= '0;
      wb_valid   <= 1'b0;
      rvfi_order <= '0;
    end else begin
      wb_valid <= capture;
      if (capture) begin
        wb_in                       <= mem_out;
        if (rd_acc) wb_in.mdr       <= dmem_rdata;
        wb_in.rvfi_d.rvfi_mem_rdata <= rd_acc ? dmem_rdata : '0;
        rvfi_order                  <= order_cnt;
      end
    end
  end

  // retire order counter, wraps modulo 2**ORDER_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      order_cnt <= '0;
    end else if (capture) begin
      order_cnt <= order_cnt + ORDER_W'(1);
    end
  end

  // mem stage must hold its request steady while stalled
  a_stable_in_wait: assert property (
    @(posedge clk) disable iff (!rst)
    (state_q == WAIT) |-> ($stable(mem_out) && $stable(mem_valid) &&
                           $stable(dmem_read) && $stable(dmem_write))
  );

endmodule

// File: tb/tb_mem_wb_buffer.sv
module tb_mem_wb_buffer;
  import rv32i_types::*;

  localparam int unsigned OW  = 4;
  localparam int unsigned TMO = 4;
  localparam int unsigned TW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  MEM_WB_stage_t mem_out;
  logic          mem_valid, dmem_read, dmem_write, dmem_resp;
  logic [31:0]   dmem_rdata;
  MEM_WB_stage_t wb_in;
  logic          wb_valid, mem_stall, timeout_err;
  logic [OW-1:0] rvfi_order;

  mem_wb_buffer #(.ORDER_W(OW), .TIMEOUT(TMO), .TO_W(TW)) dut (
    .clk(clk), .rst(rst), .mem_out(mem_out), .mem_valid(mem_valid),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .wb_in(wb_in), .wb_valid(wb_valid),
    .mem_stall(mem_stall), .rvfi_order(rvfi_order), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          mv, rd, wr, resp;
    logic [31:0] rdata, alu;
    bit          stall;
  } vec_t;

  typedef struct {
    logic [31:0]   alu, mdr, rdat;
    logic [OW-1:0] ord;
  } exp_t;

  exp_t          exp_q[$];
  vec_t          vecs[$];
  int            checks = 0;
  int            failures = 0;
  bit            m_wait;
  logic [OW-1:0] m_ord;
  logic [31:0]   last_alu;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(bit r, bit mv, bit rd, bit wr, bit resp,
                              logic [31:0] rdata, logic [31:0] alu, bit stall);
    vec_t v;
    v.do_rst = r; v.mv = mv; v.rd = rd; v.wr = wr; v.resp = resp;
    v.rdata = rdata; v.alu = alu; v.stall = stall;
    return v;
  endfunction

  task automatic idle_inputs();
    mem_out = '0; mem_valid = 0; dmem_read = 0; dmem_write = 0;
    dmem_resp = 0; dmem_rdata = '0;
  endtask

  task automatic model_reset();
    m_wait = 0; m_ord = '0; last_alu = '0;
    exp_q.delete();
  endtask

  // reset pulse entered and left at posedge+1
  task automatic do_reset();
    rst = 0;
    idle_inputs();
    #1;
    @(posedge clk); #1;
    rst = 1;
    model_reset();
  endtask

  // compare the registered output against the scoreboard head
  task automatic check_retire();
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wb_valid", 64'(wb_valid), 64'd1);
      chk("alu_out", 64'(wb_in.alu_out), 64'(e.alu));
      chk("mdr", 64'(wb_in.mdr), 64'(e.mdr));
      chk("rvfi_mem_rdata", 64'(wb_in.rvfi_d.rvfi_mem_rdata), 64'(e.rdat));
      chk("rvfi_order", 64'(rvfi_order), 64'(e.ord));
      last_alu = e.alu;
    end else begin
      chk("wb_valid_idle", 64'(wb_valid), 64'd0);
      chk("wb_in_held", 64'(wb_in.alu_out), 64'(last_alu));
    end
  endtask

  // one cycle: drive at posedge+1, check stall, predict, clock, check retire
  task automatic step(input vec_t v);
    exp_t e;
    bit acc, cap;
    mem_out = '0;
    mem_out.alu_out = v.alu;
    mem_out.mdr = ~v.alu;
    mem_out.pc = v.alu + 32'h1000;
    mem_out.rvfi_d.rvfi_mem_rdata = 32'h1111_1111;
    mem_valid = v.mv; dmem_read = v.rd; dmem_write = v.wr;
    dmem_resp = v.resp; dmem_rdata = v.rdata;
    #1;
    chk("mem_stall", 64'(mem_stall), 64'(v.stall));
    acc = v.mv & (v.rd | v.wr);
    cap = 0;
    if (m_wait) begin
      if (v.resp) begin cap = 1; m_wait = 0; end
    end else if (acc && !v.resp) begin
      m_wait = 1;
    end else if (v.mv) begin
      cap = 1;
    end
    if (cap) begin
      e.alu  = v.alu;
      e.mdr  = (v.mv && v.rd) ? v.rdata : ~v.alu;
      e.rdat = (v.mv && v.rd) ? v.rdata : 32'h0;
      e.ord  = m_ord;
      m_ord  = m_ord + 1'b1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    check_retire();
  endtask

  initial begin
    // ALU op, then a 3-cycle load
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h1234, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0, 32'h100, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'hDEADBEEF, 32'h100, 0));
    // zero-wait store, stale resp on a bubble, zero-wait load
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'h5555, 32'h200, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h7777, 32'h300, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'hCAFEF00D, 32'h400, 0));
    // fresh reset, 10 back-to-back ALU ops, a bubble, then wrap the 4-bit order
    for (int i = 0; i < 10; i++) vecs.push_back(mk(i == 0, 1, 0, 0, 0, 32'h0, 32'h1000 + i, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'hBAD, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h2000 + i, 0));

    rst = 1;
    idle_inputs();
    model_reset();
    #1 rst = 0;
    mem_valid = 1; dmem_read = 1;   // stall must stay low while in reset
    #1;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_rvfi_order", 64'(rvfi_order), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_mem_stall", 64'(mem_stall), 64'd0);
    chk("rst_wb_in", 64'(wb_in.alu_out), 64'd0);
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 1;

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      step(vecs[i]);
    end
    chk("no_timeout_short_wait", 64'(timeout_err), 64'd0);

    // load never answered: flag after the 4th wait cycle, sticky past resp
    for (int k = 1; k <= 8; k++) begin
      step(mk(0, 1, 1, 0, 0, 32'h0, 32'h500, 1));
      chk($sformatf("timeout_err_k%0d", k), 64'(timeout_err), (k >= 5) ? 64'd1 : 64'd0);
    end
    step(mk(0, 1, 1, 0, 1, 32'h600D, 32'h500, 0));
    chk("timeout_sticky_resp", 64'(timeout_err), 64'd1);
    step(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
    chk("timeout_sticky_idle", 64'(timeout_err), 64'd1);

    // async reset in the middle of WAIT
    step(mk(0, 1, 1, 0, 0, 32'h0, 32'h700, 1));
    step(mk(0, 1, 1, 0, 0, 32'h0, 32'h700, 1));
    rst = 0;
    #1;
    chk("arst_wb_valid", 64'(wb_valid), 64'd0);
    chk("arst_wb_in", 64'(wb_in.alu_out), 64'd0);
    chk("arst_rvfi_order", 64'(rvfi_order), 64'd0);
    chk("arst_timeout_err", 64'(timeout_err), 64'd0);
    chk("arst_mem_stall", 64'(mem_stall), 64'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    // stale responses with no access must not retire anything
    step(mk(0, 0, 0, 0, 1, 32'h9999, 32'h700, 0));
    step(mk(0, 0, 0, 0, 1, 32'h9999, 32'h700, 0));
    step(mk(0, 1, 0, 0, 0, 32'h0, 32'h800, 0));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
